// File: rtl/gpu_line_pkg.sv
// Shared types for the 2D GPU line-draw scheduler and its round-robin arbiter.
package gpu_line_pkg;

    localparam int DEF_COORD_W = 8;

    typedef logic [DEF_COORD_W-1:0] coord_t;

    typedef enum logic [2:0] {
        IDLE,
        CLR_ENTER,
        CLR_EXIT,
        ISSUE,
        WAIT_DONE,
        RETIRE
    } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin search: first asserted request at or above rr_ptr, wrapping.
module rr_arbiter #(
    parameter  int NUM_REQ = 2,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic               gnt_valid,
    output logic [IDX_W-1:0]   gnt_idx
);

    logic [IDX_W-1:0] w_idx;

    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        w_idx     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (!gnt_valid && req[w_idx]) begin
                gnt_valid = 1'b1;
                gnt_idx   = w_idx;
            end
        end
    end

endmodule

// File: rtl/line_draw_sched.sv
// Schedules line draws and frame-buffer clears onto the shared Bresenham rasterizer.
// Define LINE_DRAW_SCHED_STATS_EN to add saturating line_count / clear_count outputs.
module line_draw_sched
    import gpu_line_pkg::*;
#(
    parameter  int NUM_REQ = 2,
    parameter  int COORD_W = DEF_COORD_W,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                       clk,
    input  logic                       n_rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*COORD_W-1:0] req_x0,
    input  logic [NUM_REQ*COORD_W-1:0] req_y0,
    input  logic [NUM_REQ*COORD_W-1:0] req_x1,
    input  logic [NUM_REQ*COORD_W-1:0] req_y1,
    output logic [NUM_REQ-1:0]         ack,
    input  logic                       clear_req,
    output logic                       clear_ack,
    output logic [COORD_W-1:0]         eng_x0,
    output logic [COORD_W-1:0]         eng_y0,
    output logic [COORD_W-1:0]         eng_x1,
    output logic [COORD_W-1:0]         eng_y1,
    output logic                       eng_start,
    output logic                       eng_reset_buff,
    input  logic                       eng_done,
`ifdef LINE_DRAW_SCHED_STATS_EN
    output logic [15:0]                line_count,
    output logic [7:0]                 clear_count,
`endif
    output logic                       busy,
    output logic [IDX_W-1:0]           grant_id
);

    sched_state_t r_state, w_next;

    logic [NUM_REQ-1:0][COORD_W-1:0] w_x0, w_y0, w_x1, w_y1;
    logic [COORD_W-1:0]              r_x0, r_y0, r_x1, r_y1;
    logic [IDX_W-1:0]                r_grant_id, r_rr_ptr;
    logic                            w_gnt_valid;
    logic [IDX_W-1:0]                w_gnt_idx;
    logic                            w_issue;

    // Packed-array view lines up exactly with the [i*COORD_W +: COORD_W] layout.
    assign w_x0 = req_x0;
    assign w_y0 = req_y0;
    assign w_x1 = req_x1;
    assign w_y1 = req_y1;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req       (req),
        .rr_ptr    (r_rr_ptr),
        .gnt_valid (w_gnt_valid),
        .gnt_idx   (w_gnt_idx)
    );

    assign w_issue = (r_state == IDLE) && !clear_req && w_gnt_valid;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next         = r_state;
        ack            = '0;
        clear_ack      = 1'b0;
        eng_start      = 1'b0;
        eng_reset_buff = 1'b0;
        busy           = (r_state != IDLE);
        case (r_state)
            IDLE: begin
                if (clear_req)        w_next = CLR_ENTER;
                else if (w_gnt_valid) w_next = ISSUE;
            end
            CLR_ENTER: begin
                eng_reset_buff = 1'b1;
                w_next         = CLR_EXIT;
            end
            CLR_EXIT: begin
                // start pulse walks the rasterizer out of its RESET state
                eng_start = 1'b1;
                clear_ack = 1'b1;
                w_next    = IDLE;
            end
            ISSUE: begin
                eng_start = 1'b1;
                w_next    = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (eng_done) w_next = RETIRE;
            end
            RETIRE: begin
                ack[r_grant_id] = 1'b1;
                w_next          = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_x0       <= '0;
            r_y0       <= '0;
            r_x1       <= '0;
            r_y1       <= '0;
            r_grant_id <= '0;
            r_rr_ptr   <= '0;
        end else begin
            if (w_issue) begin
                r_x0       <= w_x0[w_gnt_idx];
                r_y0       <= w_y0[w_gnt_idx];
                r_x1       <= w_x1[w_gnt_idx];
                r_y1       <= w_y1[w_gnt_idx];
                r_grant_id <= w_gnt_idx;
            end
            if (r_state == RETIRE)
                r_rr_ptr <= (r_grant_id == IDX_W'(NUM_REQ - 1)) ? '0 : r_grant_id + 1'b1;
        end
    end

    assign eng_x0   = r_x0;
    assign eng_y0   = r_y0;
    assign eng_x1   = r_x1;
    assign eng_y1   = r_y1;
    assign grant_id = r_grant_id;

`ifdef LINE_DRAW_SCHED_STATS_EN
    logic [15:0] r_line_count;
    logic [7:0]  r_clear_count;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_line_count  <= '0;
            r_clear_count <= '0;
        end else begin
            if (r_state == RETIRE && r_line_count != '1)
                r_line_count <= r_line_count + 1'b1;
            if (r_state == CLR_EXIT && r_clear_count != '1)
                r_clear_count <= r_clear_count + 1'b1;
        end
    end

    assign line_count  = r_line_count;
    assign clear_count = r_clear_count;
`endif

endmodule
